// File: rtl/dsram_pkg.sv
// rtl/dsram_pkg.sv - shared constants for the data SRAM arbiter
package dsram_pkg;
    localparam logic PORT0              = 1'b0;
    localparam logic PORT1              = 1'b1;
    localparam int   DSRAM_NPORT        = 2;
    localparam int   DSRAM_STARVE_LIMIT = 4;
    localparam int   STARVE_W           = 4;
endpackage

// File: rtl/dsram_arbiter_if.sv
// rtl/dsram_arbiter_if.sv - requester-side port bundle of the data SRAM arbiter
interface dsram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              rready;

    modport master (output req, we, addr, wdata, rready, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, rready, output gnt, rvalid, rdata);
endinterface

// File: rtl/dsram_resp_buf.sv
// rtl/dsram_resp_buf.sv - one-entry read response buffer for one requester
module dsram_resp_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              full
);
    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    // The arbiter never issues a read to a port whose buffer is full, so
    // in_valid and full_q are never high together.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q) begin
            if (out_ready) full_d = 1'b0;
        end else if (in_valid && !out_ready) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign out_valid = full_q | in_valid;
    assign out_data  = full_q ? data_q : (in_valid ? in_data : '0);
    assign full      = full_q;
endmodule

// File: rtl/dsram_arbiter.sv
// rtl/dsram_arbiter.sv - two-port arbiter in front of the single-port data SRAM
module dsram_arbiter
    import dsram_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = DSRAM_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    dsram_arbiter_if.slave    p0,
    dsram_arbiter_if.slave    p1,
    output logic              data_sram_en,
    output logic [3:0]        data_sram_wen,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic [DATA_W-1:0] data_sram_rdata
);
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic                inflight_vld_q, inflight_vld_d;
    logic                inflight_id_q, inflight_id_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                resp0, resp1, full0, full1;
    logic                elig0, elig1, force1, gnt0, gnt1;
    logic                rvalid0, rvalid1;
    logic [DATA_W-1:0]   rdata0, rdata1;

    assign resp0 = inflight_vld_q && (inflight_id_q == PORT0);
    assign resp1 = inflight_vld_q && (inflight_id_q == PORT1);

    // A port may issue while its previous read returns only if it consumes that data now.
    assign elig0  = p0.req && !full0 && (!resp0 || p0.rready);
    assign elig1  = p1.req && !full1 && (!resp1 || p1.rready);
    assign force1 = elig1 && (starve_cnt_q == LIMIT);
    assign gnt1   = force1 || (elig1 && !elig0);
    assign gnt0   = elig0 && !force1;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt1 || !p1.req) begin
            starve_cnt_d = '0;
        end else if (elig1 && starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        inflight_vld_d  = 1'b0;
        inflight_id_d   = PORT0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        if (gnt0) begin
            inflight_vld_d  = (p0.we == 4'b0);
            data_sram_en    = 1'b1;
            data_sram_wen   = p0.we;
            data_sram_addr  = p0.addr;
            data_sram_wdata = p0.wdata;
        end else if (gnt1) begin
            inflight_vld_d  = (p1.we == 4'b0);
            inflight_id_d   = PORT1;
            data_sram_en    = 1'b1;
            data_sram_wen   = p1.we;
            data_sram_addr  = p1.addr;
            data_sram_wdata = p1.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_vld_q <= 1'b0;
            inflight_id_q  <= PORT0;
            starve_cnt_q   <= '0;
        end else begin
            inflight_vld_q <= inflight_vld_d;
            inflight_id_q  <= inflight_id_d;
            starve_cnt_q   <= starve_cnt_d;
        end
    end

    dsram_resp_buf #(.DATA_W(DATA_W)) u_buf0 (
        .clk(clk), .rst(rst), .in_valid(resp0), .in_data(data_sram_rdata),
        .out_ready(p0.rready), .out_valid(rvalid0), .out_data(rdata0), .full(full0)
    );

    dsram_resp_buf #(.DATA_W(DATA_W)) u_buf1 (
        .clk(clk), .rst(rst), .in_valid(resp1), .in_data(data_sram_rdata),
        .out_ready(p1.rready), .out_valid(rvalid1), .out_data(rdata1), .full(full1)
    );

    assign p0.gnt    = gnt0;
    assign p1.gnt    = gnt1;
    assign p0.rvalid = rvalid0;
    assign p1.rvalid = rvalid1;
    assign p0.rdata  = rdata0;
    assign p1.rdata  = rdata1;
endmodule
